// File: rtl/ps2_receive_if.sv
// Bundle of PS/2 receiver pins, control and result signals.
// master: the receiver (reads pins, drives results); slave: the consumer side.
interface ps2_receive_if;
  logic       ps2c;
  logic       ps2d;
  logic       rx_enable;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_err;
  logic       rx_idle;

  modport master (
    input  ps2c,
    input  ps2d,
    input  rx_enable,
    output dout,
    output rx_done_tick,
    output parity_err,
    output frame_err,
    output timeout_err,
    output rx_idle
  );

  modport slave (
    output ps2c,
    output ps2d,
    output rx_enable,
    input  dout,
    input  rx_done_tick,
    input  parity_err,
    input  frame_err,
    input  timeout_err,
    input  rx_idle
  );
endinterface

// File: rtl/ps2_receive.sv
// Device-to-host PS/2 receiver: synchronizes and filters ps2c, samples ps2d on
// each accepted falling edge, and assembles start/8 data/odd parity/stop frames.
module ps2_receive #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input logic           clk,
  input logic           reset,
  ps2_receive_if.master bus
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  // Input conditioning
  logic [1:0]            c_sync_q, c_sync_d;
  logic [1:0]            d_sync_q, d_sync_d;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fc_q, fc_d;
  logic                  filt_zero, filt_one;
  logic                  fall_tick;
  logic                  rx_bit;

  // FSM and datapath
  state_e          state_q, state_d;
  logic [3:0]      n_q, n_d;
  logic [9:0]      shreg_q, shreg_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      dout_q, dout_d;
  logic            to_pulse_q, to_pulse_d;

  // Synchronizer/filter next state; fc only moves on a full run of equal samples
  always_comb begin
    c_sync_d  = {c_sync_q[0], bus.ps2c};
    d_sync_d  = {d_sync_q[0], bus.ps2d};
    filt_d    = {c_sync_q[1], filt_q[FILTER_LEN-1:1]};
    filt_zero = (filt_q == '0);
    filt_one  = &filt_q;
    fc_d      = fc_q;
    if (filt_one) begin
      fc_d = 1'b1;
    end else if (filt_zero) begin
      fc_d = 1'b0;
    end
    // High for exactly the one cycle between filter going all-zero and fc dropping
    fall_tick = filt_zero & fc_q;
    rx_bit    = d_sync_q[1];
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_q   <= 2'b11;
      d_sync_q   <= 2'b11;
      filt_q     <= '1;
      fc_q       <= 1'b1;
      state_q    <= StIdle;
      n_q        <= '0;
      shreg_q    <= '0;
      tmo_q      <= '0;
      dout_q     <= '0;
      to_pulse_q <= 1'b0;
    end else begin
      c_sync_q   <= c_sync_d;
      d_sync_q   <= d_sync_d;
      filt_q     <= filt_d;
      fc_q       <= fc_d;
      state_q    <= state_d;
      n_q        <= n_d;
      shreg_q    <= shreg_d;
      tmo_q      <= tmo_d;
      dout_q     <= dout_d;
      to_pulse_q <= to_pulse_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    shreg_d    = shreg_q;
    tmo_d      = tmo_q;
    dout_d     = dout_q;
    to_pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall_tick && !rx_bit && bus.rx_enable) begin
          state_d = StRecv;
          n_d     = 4'd9;
          tmo_d   = '0;
        end
      end
      StRecv: begin
        if (!bus.rx_enable) begin
          // Silent abort: enable loss beats a coincident timeout
          state_d = StIdle;
        end else if (fall_tick) begin
          shreg_d = {rx_bit, shreg_q[9:1]};
          tmo_d   = '0;
          n_d     = n_q - 4'd1;
          if (n_q == 4'd0) begin
            // Stop bit just arrived: publish the byte so it is valid in DONE
            state_d = StDone;
            dout_d  = shreg_d[7:0];
          end
        end else if (tmo_q == TmoMax) begin
          state_d    = StIdle;
          to_pulse_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: strobes decode DONE; shreg holds {stop, parity, d7..d0} there
  always_comb begin
    bus.dout         = dout_q;
    bus.rx_done_tick = (state_q == StDone);
    bus.parity_err   = (state_q == StDone) & ~(^shreg_q[8:0]);
    bus.frame_err    = (state_q == StDone) & ~shreg_q[9];
    bus.timeout_err  = to_pulse_q;
    bus.rx_idle      = (state_q == StIdle);
  end

endmodule

// File: tb/tb_ps2_receive.sv
// Scoreboard bench for ps2_receive: stimulus pushes expected events, a monitor
// pops and compares whenever the receiver strobes a result.
module tb_ps2_receive;

  typedef struct packed {
    logic       is_to;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ps2_receive_if bus ();

  ps2_receive #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(20000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail = 0;
  int   n_pushed = 0;
  int   n_events = 0;
  ev_t  exp_q[$];
  ev_t  mon_ev;
  logic [7:0] exp_dout = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set while clock high, then a low half-period
  task automatic send_bit(input logic b, input int half, input logic glitch);
    bus.ps2d = b;
    if (glitch) begin
      wait_cyc(half / 2);
      bus.ps2c = 1'b0;
      wait_cyc(3);
      bus.ps2c = 1'b1;
      wait_cyc(half - half / 2 - 3);
    end else begin
      wait_cyc(half);
    end
    bus.ps2c = 1'b0;
    wait_cyc(half);
    bus.ps2c = 1'b1;
  endtask

  // Sends the first nbits of a frame; a full frame with enable high is expected to complete
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int half, input int nbits, input logic glitch,
                            input logic expect_it);
    logic [10:0] bits;
    ev_t ev;
    bits = {stop, par, data, 1'b0};
    if (expect_it) begin
      ev.is_to = 1'b0;
      ev.data  = data;
      ev.perr  = ($countones({par, data}) % 2) == 0;
      ev.ferr  = !stop;
      exp_q.push_back(ev);
      n_pushed++;
      exp_dout = data;
    end
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i], half, glitch);
    end
    bus.ps2d = 1'b1;
    wait_cyc(half);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_done_tick || bus.timeout_err) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got done=%0b timeout=%0b dout=%02h, required none",
                   bus.rx_done_tick, bus.timeout_err, bus.dout);
        end else begin
          mon_ev = exp_q.pop_front();
          n_events++;
          check("event_timeout", bus.timeout_err, mon_ev.is_to);
          check("event_done", bus.rx_done_tick, !mon_ev.is_to);
          check("dout", bus.dout, mon_ev.data);
          check("parity_err", bus.parity_err, mon_ev.perr);
          check("frame_err", bus.frame_err, mon_ev.ferr);
        end
      end else if (bus.parity_err || bus.frame_err) begin
        check("err_without_done", {bus.parity_err, bus.frame_err}, 0);
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ev_t  tev;
    logic [7:0] d;
    logic p, s, g;
    int h;

    bus.ps2c = 1'b1;
    bus.ps2d = 1'b1;
    bus.rx_enable = 1'b1;
    reset = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    check("reset_dout", bus.dout, 8'h00);
    check("reset_idle", bus.rx_idle, 1'b1);
    check("reset_done", bus.rx_done_tick, 1'b0);
    check("reset_perr", bus.parity_err, 1'b0);
    check("reset_ferr", bus.frame_err, 1'b0);
    check("reset_timeout", bus.timeout_err, 1'b0);
    wait_cyc(20);

    // Good frame at a slow PS/2 clock, then parity and stop errors
    send_frame(8'h1C, 1'b0, 1'b1, 500, 11, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1, 50, 11, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b1, 1'b0, 50, 11, 1'b0, 1'b1);
    wait_cyc(20);
    check("dout_after_errs", bus.dout, 8'hAA);

    // Truncated frame then inactivity
    tev.is_to = 1'b1;
    tev.data  = exp_dout;
    tev.perr  = 1'b0;
    tev.ferr  = 1'b0;
    exp_q.push_back(tev);
    n_pushed++;
    send_frame(8'h3C, 1'b0, 1'b1, 50, 5, 1'b0, 1'b0);
    wait_cyc(25000);
    check("timeout_idle", bus.rx_idle, 1'b1);
    check("timeout_dout_hold", bus.dout, exp_dout);
    send_frame(8'h1C, 1'b0, 1'b1, 50, 11, 1'b0, 1'b1);

    // Short glitches in idle and between bits
    bus.ps2c = 1'b0;
    wait_cyc(3);
    bus.ps2c = 1'b1;
    wait_cyc(30);
    check("glitch_idle", bus.rx_idle, 1'b1);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, 50, 11, 1'b1, 1'b1);
    wait_cyc(20);
    check("glitch_dout", bus.dout, 8'h5A);

    // Enable dropped mid-frame: rest of the frame must be ignored
    send_frame(8'h12, odd_par(8'h12), 1'b1, 50, 5, 1'b0, 1'b0);
    bus.rx_enable = 1'b0;
    wait_cyc(5);
    check("abort_idle", bus.rx_idle, 1'b1);
    send_bit(1'b0, 50, 1'b0);
    send_bit(1'b0, 50, 1'b0);
    send_bit(1'b0, 50, 1'b0);
    send_bit(1'b0, 50, 1'b0);
    send_bit(odd_par(8'h12), 50, 1'b0);
    send_bit(1'b1, 50, 1'b0);
    bus.ps2d = 1'b1;
    wait_cyc(50);
    bus.rx_enable = 1'b1;
    check("abort_dout_hold", bus.dout, 8'h5A);

    // Back-to-back frames
    send_frame(8'hF0, odd_par(8'hF0), 1'b1, 50, 11, 1'b0, 1'b1);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, 50, 11, 1'b0, 1'b1);

    // Randomized frames with occasional parity/stop errors and glitches
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom);
      p = odd_par(d);
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = ($urandom_range(0, 3) != 0);
      g = 1'($urandom_range(0, 1));
      h = int'($urandom_range(30, 60));
      send_frame(d, p, s, h, 11, g, 1'b1);
      wait_cyc(int'($urandom_range(0, 40)));
    end

    // Reset mid-frame discards the partial frame
    send_frame(8'h77, 1'b0, 1'b1, 50, 6, 1'b0, 1'b0);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    exp_dout = 8'h00;
    wait_cyc(20);
    check("midreset_dout", bus.dout, 8'h00);
    check("midreset_idle", bus.rx_idle, 1'b1);
    send_frame(8'h3E, odd_par(8'h3E), 1'b1, 40, 11, 1'b0, 1'b1);

    // Drain with a bounded wait
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) wait_cyc(1);
    check("queue_drained", exp_q.size(), 0);
    check("event_count", n_events, n_pushed);
    check("final_dout", bus.dout, exp_dout);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
